// File: rtl/risc_mem_responder.sv
// rtl/risc_mem_responder.sv - req/ack memory responder with wait states and a side load port
// Optional MEM_STATS_EN adds saturating completed-read/write counters.
module risc_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_done_o
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              load_done_q, load_done_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              acc_rd, acc_wr;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        load_done_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = wdata_q;
        acc_rd      = 1'b0;
        acc_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Loader wins over the CU; the request is picked up on a later IDLE edge.
                if (load_en_i) begin
                    mem_we      = 1'b1;
                    mem_waddr   = load_addr_i;
                    mem_wdata   = load_data_i;
                    load_done_d = 1'b1;
                end else if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wcnt_d  = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                    if (we_q) begin
                        mem_we = 1'b1;
                        acc_wr = 1'b1;
                    end else begin
                        rdata_d = mem[addr_q];
                        acc_rd  = 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            load_done_q <= load_done_d;
        end
    end

    // Array contents survive reset, but a write in flight when reset hits is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            if (acc_rd && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (acc_wr && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign load_done_o = load_done_q;

endmodule

// File: doc/risc_mem_responder.md
# risc_mem_responder

Memory-side responder for the RISC machine's 256x16 data/instruction store. The control unit starts each memory access; this block completes it over a req/ack handshake, with a configurable number of wait states. A side load port lets a bench or boot loader fill memory before or between CPU accesses. The block replaces a zero-latency array, so the CPU state machine can be exercised against a slow memory.

## Interface
Parameters:
- `ADDR_W`, 8, address width; depth = 2**ADDR_W words
- `DATA_W`, 16, word width
- `WAIT_CYCLES`, 2, wait states inserted before each access; range 0..15

Ports:
- `clk`  in  1  system clock; all logic acts on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `req`  in  1  access request from the CU; held high until `ack` is seen
- `we`  in  1  1 = write, 0 = read; sampled together with `req`
- `addr`  in  ADDR_W  word address
- `wdata`  in  DATA_W  write data
- `ack`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_W  read data; valid while `ack`=1
- `busy`  out  1  high in every state except IDLE
- `load_en`  in  1  load-port write request
- `load_addr`  in  ADDR_W  load address
- `load_data`  in  DATA_W  load data
- `load_done`  out  1  one-cycle pulse after each accepted load write

## Operation
- The array is `mem[0:2**ADDR_W-1]` of DATA_W bits. Reset does not clear its contents.
- FSM states are IDLE, WAIT and DONE. A wait counter `wcnt` has 4 bits.
- IDLE:
  - If `load_en`=1, write `mem[load_addr]` with `load_data`, set `load_done`=1 and stay in IDLE. The load port has priority over `req`.
  - Otherwise, if `req`=1, latch `we`, `addr` and `wdata`, set `wcnt`=WAIT_CYCLES and go to WAIT.
- WAIT:
  - If `wcnt`≠0, decrement `wcnt`.
  - If `wcnt`=0, perform the access and go to DONE:
    - write: `mem[addr_q]` takes `wdata_q`; `rdata` keeps its value.
    - read: `rdata` takes `mem[addr_q]`.
    - In both cases `ack` is set to 1.
- DONE: clear `ack` and return to IDLE. `req` and `load_en` are ignored in this state.
- While the block is not in IDLE, `load_en` is ignored and `load_done` stays 0. The loader holds `load_en` until it sees `load_done`. If `load_en` is still high in the `load_done` cycle, the same write repeats, which is harmless.
- The CU must drop `req` in its `ack` cycle. A `req` still high on return to IDLE is taken as a new request.
- Changes to `addr`, `wdata` or `we` after the sampling edge have no effect on the access in flight.
- Read-after-write to the same address returns the new data, because writes complete before the next request is accepted.

## Timing
- Reset values: `ack`=0, `rdata`=0, `busy`=0, `load_done`=0, state=IDLE, `wcnt`=0.
- Reset asserted mid-transaction aborts it. A pending write is not performed and `ack` is not raised.
- Request path, with E0 the edge that samples `req` in IDLE:
  - The access is performed and `ack` rises at edge E0+WAIT_CYCLES+1.
  - `ack` is high for exactly one cycle.
  - The block is back in IDLE after edge E0+WAIT_CYCLES+2.
  - The earliest next request is sampled at edge E0+WAIT_CYCLES+3.
- Throughput is one access per WAIT_CYCLES+3 cycles.
- Load path: the write and `load_done` both happen at the sampling edge. Back-to-back loads are possible, one per cycle.
- If `req` and `load_en` are both high in IDLE, the load happens first and `req` is sampled at the next IDLE edge. This adds one cycle to the request's latency.
- `busy` goes high the cycle after the sampling edge and low the cycle after DONE.

## Configuration
- `MEM_STATS_EN` defined:
  - Adds output `rd_cnt` (16 bits) and output `wr_cnt` (16 bits).
  - Each counter increments on every completed read or write access respectively, at the edge that raises `ack`.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Load-port writes are not counted.
- `MEM_STATS_EN` not defined: neither the ports nor the counter logic exist. All other behaviour is identical.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles, then release → `ack`=0, `busy`=0, `rdata`=16'h0000, `load_done`=0.
- Load then read, WAIT_CYCLES=2: load 16'hA5A5 at 8'd203 (one `load_done` pulse), then request a read of 203 → `ack` rises 3 edges after sampling, with `rdata`=16'hA5A5.
- Write then read, WAIT_CYCLES=0: write 16'h1234 to 8'd205 → `ack` after 1 edge; reread 205 → 16'h1234; throughput is one access per 3 cycles.
- Simultaneous requests: `req`=1 (read of 8'd10) and `load_en`=1 (8'd10 ← 16'hBEEF) in the same IDLE cycle → load first, read returns 16'hBEEF, `ack` delayed by 1 cycle.
- Abort and held request: assert `rst`=0 during WAIT of a write of 16'hFFFF to 8'd7 → `mem[7]` unchanged and no `ack`; with `req` held through DONE → a second access starts.
- With `MEM_STATS_EN`: 3 reads, 2 writes and 4 loads → `rd_cnt`=3, `wr_cnt`=2.
